// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit producing the HI/LO pair.
// Shift-add multiply and restoring divide, one bit per cycle, with a final
// sign-correction state. A divide by zero is rejected in IDLE with a done pulse.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    // mult: multiplicand |a|; div: divisor |b|
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // mult: multiplier shifted right; div: dividend shifted out, quotient shifted in
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    // mult: 2W accumulator; div: partial remainder in the low W bits
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, trial, diff;
    logic [2*WIDTH-1:0] prod;

    // Next-state logic: accept, iterate, then sign-fix and publish results.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        opnd_d     = opnd_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_signed  = ~op_i[0];
        a_mag      = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag      = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
        sum        = '0;
        trial      = '0;
        diff       = '0;
        prod       = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (op_i[1] && (b_i == '0)) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d    = StRun;
                        cnt_d      = CntW'(WIDTH - 1);
                        is_div_d   = op_i[1];
                        neg_res_d  = is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        neg_rem_d  = is_signed & a_i[WIDTH-1];
                        opnd_d     = op_i[1] ? b_mag : a_mag;
                        shreg_d    = op_i[1] ? a_mag : b_mag;
                        acc_d      = '0;
                        div_zero_d = 1'b0;
                    end
                end
            end
            StRun: begin
                if (is_div_q) begin
                    trial = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
                    diff  = trial - {1'b0, opnd_q};
                    if (!diff[WIDTH]) begin
                        acc_d   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                            + (shreg_q[0] ? {1'b0, opnd_q} : '0);
                    acc_d   = {sum, acc_q[WIDTH-1:1]};
                    shreg_d = shreg_q >> 1;
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = neg_res_q ? -shreg_q : shreg_q;
                    hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    prod = neg_res_q ? -acc_q : acc_q;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            opnd_q     <= '0;
            shreg_q    <= '0;
            acc_q      <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            opnd_q     <= opnd_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH = 32 and WIDTH = 8.
module tb_mult_div_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start32, start8;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    exp_t sb32[$];
    exp_t sb8[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start32),
        .op_i       (op_r),
        .a_i        (a_r),
        .b_i        (b_r),
        .busy_o     (busy32),
        .done_o     (done32),
        .div_zero_o (dz32),
        .hi_o       (hi32),
        .lo_o       (lo32)
    );

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start8),
        .op_i       (op_r),
        .a_i        (a_r[7:0]),
        .b_i        (b_r[7:0]),
        .busy_o     (busy8),
        .done_o     (done8),
        .div_zero_o (dz8),
        .hi_o       (hi8),
        .lo_o       (lo8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the 32-bit unit: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (done32) begin
            chk("busy_done_excl32", {31'b0, busy32}, 32'd0);
            if (sb32.size() == 0) begin
                chk("unexpected_done32", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb32.pop_front();
                chk("hi32", hi32, e.hi);
                chk("lo32", lo32, e.lo);
                chk("dz32", {31'b0, dz32}, {31'b0, e.dz});
            end
        end
    end

    // Monitor for the 8-bit unit.
    always @(negedge clk) begin
        if (done8) begin
            chk("busy_done_excl8", {31'b0, busy8}, 32'd0);
            if (sb8.size() == 0) begin
                chk("unexpected_done8", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                chk("hi8", {24'b0, hi8}, e.hi);
                chk("lo8", {24'b0, lo8}, e.lo);
                chk("dz8", {31'b0, dz8}, {31'b0, e.dz});
            end
        end
    end

    // Issue one operation, then check latency, busy span and done width.
    task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input bit mess);
        int lat;
        int nb;
        int exp_lat;
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.dz = edz;
        exp_lat = edz ? 0 : (w8 ? 9 : 33);
        if (w8) sb8.push_back(e);
        else    sb32.push_back(e);
        @(negedge clk);
        op_r = op; a_r = a; b_r = b;
        if (w8) start8 = 1'b1;
        else    start32 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        lat = 0;
        nb  = 0;
        while (!(w8 ? done8 : done32) && lat < 60) begin
            if (w8 ? busy8 : busy32) nb++;
            if (mess && lat == 5) begin
                start32 = 1'b1; op_r = ~op_r; a_r = $urandom; b_r = $urandom;
            end
            if (mess && lat == 6) start32 = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("busy_cycles", nb, exp_lat);
        @(negedge clk);
        chk("done_width", {31'b0, (w8 ? done8 : done32)}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0; op_r = 2'b00; a_r = '0; b_r = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy32}, 32'd0);
        chk("rst_done", {31'b0, done32}, 32'd0);
        chk("rst_dz", {31'b0, dz32}, 32'd0);
        chk("rst_hi", hi32, 32'd0);
        chk("rst_lo", lo32, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_hilo", hi32 | lo32, 32'd0);

        run_op(0, 2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0);
        run_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
        run_op(0, 2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        run_op(0, 2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 0, 0);
        run_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0);
        // Divide by zero keeps the previous hi/lo.
        run_op(0, 2'b10, 32'd5,        32'd0,        32'h00000000, 32'h80000000, 1, 0);
        repeat (3) @(negedge clk);
        chk("dz_sticky", {31'b0, dz32}, 32'd1);
        chk("dz_no_busy", {31'b0, busy32}, 32'd0);
        // Next valid start clears the flag; mid-run stimulus must be ignored.
        run_op(0, 2'b00, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 0, 1);
        run_op(0, 2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 0);
        run_op(0, 2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 0, 0);

        run_op(1, 2'b00, 32'h80,       32'h80,       32'h40,       32'h00,       0, 0);
        run_op(1, 2'b11, 32'hFF,       32'h10,       32'h0F,       32'h0F,       0, 0);
        run_op(1, 2'b10, 32'h80,       32'hFF,       32'h00,       32'h80,       0, 0);
        run_op(1, 2'b10, 32'hF9,       32'h02,       32'hFF,       32'hFD,       0, 0);

        // Reset in the middle of a multiply: immediate clear, no done.
        @(negedge clk);
        op_r = 2'b01; a_r = 32'hFFFF0000; b_r = 32'h00010001; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy32}, 32'd0);
        chk("midrst_done", {31'b0, done32}, 32'd0);
        chk("midrst_hi", hi32, 32'd0);
        chk("midrst_lo", lo32, 32'd0);
        repeat (40) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op(0, 2'b00, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 0, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb32.size() + sb8.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multicycle multiply/divide unit that produces the HI/LO pair for the multicycle MIPS datapath. It replaces the fixed 32-bit HI/LO source feeding RegData_mux. It is generalised in operand width and supports four modes: signed multiply, unsigned multiply, signed divide and unsigned divide. It has a start/busy/done handshake so the control unit can wait on it.

## Interface
Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits; WIDTH ≥ 4.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately when 0.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 = mult (signed), 01 = multu, 10 = div (signed), 11 = divu; sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- busy  out  1  high while an operation is in progress (RUN or FIX).
- done  out  1  single-cycle pulse when a result, or a divide-by-zero abort, is final.
- div_zero  out  1  sticky flag; set when a div/divu with b = 0 is accepted.
- hi  out  WIDTH  product[2W-1:W], or remainder.
- lo  out  WIDTH  product[W-1:0], or quotient.

## Operation
- Reset state (reset = 0): state = IDLE, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, and internal counter/accumulators = 0.
- States:
  - IDLE → RUN when start = 1 and the request is not a divide-by-zero.
  - RUN → FIX when the iteration counter reaches 0.
  - FIX → IDLE unconditionally.
- Accept (IDLE, start = 1):
  - Latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned ops).
  - Latch the result sign bits.
  - Load counter = WIDTH-1.
  - Clear div_zero.
- Divide-by-zero: if op[1] = 1 and b = 0 at accept, stay in IDLE, assert done for one cycle and set div_zero = 1. hi and lo hold their previous values.
- RUN, multiply: shift-add, one multiplier bit per cycle, with a 2·WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, with a WIDTH+1 bit partial remainder.
- In RUN the counter decrements once per cycle, giving exactly WIDTH iterations.
- FIX:
  - Apply the sign correction and write hi/lo.
  - Assert done for the following cycle.
  - Deassert busy.
- Sign rules, signed ops only:
  - Product is negated (2·WIDTH two's complement) if sign(a) ≠ sign(b).
  - Quotient is negated if sign(a) ≠ sign(b); quotient truncates toward zero.
  - Remainder takes the sign of a.
  - Most-negative / -1 gives lo = most-negative (wraps) and hi = 0. No flag is raised.
- hi and lo change only in FIX (or on reset). Otherwise they hold, so the datapath can read them at any time.
- start while busy = 1: ignored, no queueing. op, a and b changes during RUN have no effect.
- start = 1 in the same cycle done = 1 (state is IDLE): accepted normally.
- Reset asserted mid-operation: abort immediately to the reset state. No done pulse.

## Timing
- Start accepted at rising edge E.
- busy is high from after edge E until after edge E+WIDTH+1.
- hi, lo and done are valid after edge E+WIDTH+1. done is low again after edge E+WIDTH+2.
- Latency is WIDTH+1 cycles (33 for WIDTH = 32). Throughput is one operation per WIDTH+2 cycles when start is held high.
- Divide-by-zero: done = 1 and div_zero = 1 after edge E, done = 0 after edge E+1. busy never rises.
- done is exactly one cycle wide. busy and done are never high together.
- Outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- Reset then mult: hold reset = 0, then release. Check all outputs are 0. Then mult a = FFFFFFFD (-3), b = 5 → after 33 cycles hi = FFFFFFFF, lo = FFFFFFF1, done pulses once.
- multu: a = b = FFFFFFFF → hi = FFFFFFFE, lo = 00000001. busy is high for exactly 33 cycles.
- div: a = FFFFFFF9 (-7), b = 2 → lo = FFFFFFFD, hi = FFFFFFFF.
- divu then overflow case:
  - divu a = 100, b = 7 → lo = 0000000E, hi = 00000002.
  - div 80000000 / FFFFFFFF → lo = 80000000, hi = 0.
- Divide by zero:
  - div a = 5, b = 0 after a prior result → done one cycle after accept, div_zero = 1, hi/lo unchanged, busy stays 0.
  - The next valid start clears div_zero.
- Robustness:
  - Pulse start and change a/b mid-RUN → result unaffected.
  - Assert reset at cycle 10 of a multiply → outputs 0 immediately, no done.
- Parametrisation: repeat with WIDTH = 8, e.g. mult 0x80 × 0x80 → hi = 40, lo = 00 after 9 cycles.
